// File: rtl/llsc_monitor_pkg.sv
// Shared definitions for the LL/SC monitor: state encodings, reset level,
// and SC result values.
package llsc_monitor_pkg;

    typedef enum logic [1:0] {
        LLSC_IDLE    = 2'd0,
        LLSC_LINKED  = 2'd1,
        LLSC_SC_BUSY = 2'd2
    } llsc_state_e;

    // Level of rst that holds the block in reset.
    localparam logic RST_ACTIVE = 1'b0;

    localparam logic SC_SUCCESS = 1'b1;
    localparam logic SC_FAIL    = 1'b0;

endpackage : llsc_monitor_pkg

// File: rtl/llsc_monitor_timer.sv
// llsc_timer: saturating link-idle counter. Counts while en_i is high,
// returns to zero on clr_i, and flags expire_o when it has reached
// TIMEOUT-1. It never wraps.
module llsc_timer
    import llsc_monitor_pkg::*;
#(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [15:0] LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise count up until saturated.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = en_i && (cnt_q == LAST);

endmodule : llsc_timer

// File: rtl/llsc_monitor.sv
// llsc_monitor: load-linked / store-conditional monitor for the MEM stage.
// Tracks the link address, drops the link on matching snoops, flushes and
// (optionally) idle timeouts, and resolves SC. A successful SC performs a
// req/ack bus store while the pipeline is stalled.
// Build option: define LLSC_TIMEOUT_EN to build the link idle timer.
module llsc_monitor
    import llsc_monitor_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int LINK_LSB = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ll_i,
    input  logic [ADDR_W-1:0] ll_addr_i,
    input  logic              sc_i,
    input  logic [ADDR_W-1:0] sc_addr_i,
    input  logic [31:0]       sc_data_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              bus_req_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_data_o,
    input  logic              bus_ack_i,
    output logic              stall_o,
    output logic              sc_done_o,
    output logic              sc_result_o,
    output logic              LLbit_o
);

    llsc_state_e state_q, state_d;

    // Only the word-select bits of the link address are kept.
    logic [ADDR_W-1:LINK_LSB] link_word_q, link_word_d;
    logic [ADDR_W-1:0]        bus_addr_q, bus_addr_d;
    logic [31:0]              bus_data_q, bus_data_d;
    logic                     sc_done_q, sc_done_d;
    logic                     sc_result_q, sc_result_d;
    // A flush arrived while the SC store was in flight: finish the
    // handshake but do not report completion.
    logic                     flushed_q, flushed_d;
    logic                     expire;

    logic sc_match;
    logic snoop_match;

    assign sc_match    = (sc_addr_i[ADDR_W-1:LINK_LSB] == link_word_q);
    assign snoop_match = (snoop_addr_i[ADDR_W-1:LINK_LSB] == link_word_q);

    // Sub-word address bits never take part in link comparisons.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ll_addr_i[LINK_LSB-1:0], snoop_addr_i[LINK_LSB-1:0]};

`ifdef LLSC_TIMEOUT_EN
    logic timer_clr;

    // Restart the idle count whenever not linked or on a re-link.
    assign timer_clr = (state_q != LLSC_LINKED) || (ll_i && !sc_i && !flush);

    llsc_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (timer_clr),
        .en_i     (state_q == LLSC_LINKED),
        .expire_o (expire)
    );
`else
    // Without the timer a link only ends on SC, re-LL, snoop, flush or reset.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign expire         = 1'b0;
`endif

    // Next-state and stall decode; event priority is
    // flush > sc > ll > snoop > timeout.
    always_comb begin
        state_d     = state_q;
        link_word_d = link_word_q;
        bus_addr_d  = bus_addr_q;
        bus_data_d  = bus_data_q;
        sc_done_d   = 1'b0;
        sc_result_d = SC_FAIL;
        flushed_d   = flushed_q;
        stall_o     = 1'b0;

        unique case (state_q)
            LLSC_IDLE: begin
                if (flush) begin
                    state_d = LLSC_IDLE;
                end else if (sc_i) begin
                    sc_done_d = 1'b1;
                end else if (ll_i) begin
                    state_d     = LLSC_LINKED;
                    link_word_d = ll_addr_i[ADDR_W-1:LINK_LSB];
                end
            end

            LLSC_LINKED: begin
                if (flush) begin
                    state_d = LLSC_IDLE;
                end else if (sc_i) begin
                    if (sc_match) begin
                        state_d    = LLSC_SC_BUSY;
                        bus_addr_d = sc_addr_i;
                        bus_data_d = sc_data_i;
                        flushed_d  = 1'b0;
                        stall_o    = 1'b1;
                    end else begin
                        state_d   = LLSC_IDLE;
                        sc_done_d = 1'b1;
                    end
                end else if (ll_i) begin
                    link_word_d = ll_addr_i[ADDR_W-1:LINK_LSB];
                end else if (snoop_we_i && snoop_match) begin
                    state_d = LLSC_IDLE;
                end else if (expire) begin
                    state_d = LLSC_IDLE;
                end
            end

            LLSC_SC_BUSY: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    state_d   = LLSC_IDLE;
                    flushed_d = 1'b0;
                    if (!(flushed_q || flush)) begin
                        sc_done_d   = 1'b1;
                        sc_result_d = SC_SUCCESS;
                    end
                end else if (flush) begin
                    flushed_d = 1'b1;
                end
            end

            default: begin
                state_d = LLSC_IDLE;
            end
        endcase
    end

    // State, link and bus registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ACTIVE) begin
            state_q     <= LLSC_IDLE;
            link_word_q <= '0;
            bus_addr_q  <= '0;
            bus_data_q  <= '0;
            sc_done_q   <= 1'b0;
            sc_result_q <= SC_FAIL;
            flushed_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            link_word_q <= link_word_d;
            bus_addr_q  <= bus_addr_d;
            bus_data_q  <= bus_data_d;
            sc_done_q   <= sc_done_d;
            sc_result_q <= sc_result_d;
            flushed_q   <= flushed_d;
        end
    end

    assign bus_req_o   = (state_q == LLSC_SC_BUSY);
    assign bus_addr_o  = bus_addr_q;
    assign bus_data_o  = bus_data_q;
    assign sc_done_o   = sc_done_q;
    assign sc_result_o = sc_result_q;
    assign LLbit_o     = (state_q != LLSC_IDLE);

endmodule : llsc_monitor

// File: tb/tb_llsc_monitor.sv
// Testbench for llsc_monitor: directed scenarios plus random traffic,
// with a behavioural link model feeding a per-cycle expectation queue.
module tb_llsc_monitor;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0, ll_i = 1'b0, sc_i = 1'b0, snoop_we_i = 1'b0, bus_ack_i = 1'b0;
    logic [31:0] ll_addr_i = '0, sc_addr_i = '0, sc_data_i = '0, snoop_addr_i = '0;
    logic        bus_req_o, stall_o, sc_done_o, sc_result_o, LLbit_o;
    logic [31:0] bus_addr_o, bus_data_o;

    llsc_monitor #(.ADDR_W(32), .LINK_LSB(2), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ll_i(ll_i), .ll_addr_i(ll_addr_i),
        .sc_i(sc_i), .sc_addr_i(sc_addr_i), .sc_data_i(sc_data_i),
        .snoop_we_i(snoop_we_i), .snoop_addr_i(snoop_addr_i),
        .bus_req_o(bus_req_o), .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_ack_i(bus_ack_i), .stall_o(stall_o), .sc_done_o(sc_done_o),
        .sc_result_o(sc_result_o), .LLbit_o(LLbit_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        llbit, req, stall, done, res;
        logic [31:0] addr, data;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Behavioural model of the link.
    bit          m_linked, m_busy, m_flushed, m_done, m_res;
    logic [29:0] m_word;
    logic [31:0] m_baddr, m_bdata;
    int          m_idle;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        m_linked = 0; m_busy = 0; m_flushed = 0; m_done = 0; m_res = 0;
        m_word = '0; m_baddr = '0; m_bdata = '0; m_idle = 0;
    endfunction

    // One clock of stimulus: drive inputs, record what should be visible
    // this cycle, then advance the model to the next cycle.
    task automatic cycle(input bit fl, input bit ll, input logic [31:0] lla,
                         input bit sc, input logic [31:0] sca, input logic [31:0] scd,
                         input bit sn, input logic [31:0] sna, input bit ack);
        obs_t o;
        bit   hit;
        @(negedge clk);
        flush = fl; ll_i = ll; ll_addr_i = lla; sc_i = sc; sc_addr_i = sca;
        sc_data_i = scd; snoop_we_i = sn; snoop_addr_i = sna; bus_ack_i = ack;

        hit = sc && m_linked && !m_busy && !fl && (sca[31:2] == m_word);
        o.llbit = m_linked || m_busy;
        o.req   = m_busy;
        o.addr  = m_baddr;
        o.data  = m_bdata;
        o.done  = m_done;
        o.res   = m_res;
        o.stall = m_busy || hit;
        exp_q.push_back(o);

        m_done = 0; m_res = 0;
        if (m_busy) begin
            if (fl) m_flushed = 1;
            if (ack) begin
                m_busy = 0;
                if (!m_flushed) begin m_done = 1; m_res = 1; end
                m_flushed = 0;
            end
        end else if (fl) begin
            m_linked = 0;
        end else if (sc) begin
            if (hit) begin
                m_busy = 1; m_flushed = 0; m_baddr = sca; m_bdata = scd;
            end else begin
                m_done = 1;
            end
            m_linked = 0;
        end else if (ll) begin
            m_linked = 1; m_word = lla[31:2]; m_idle = 0;
        end else if (m_linked && sn && (sna[31:2] == m_word)) begin
            m_linked = 0;
`ifdef LLSC_TIMEOUT_EN
        end else if (m_linked) begin
            if (m_idle == TMO - 1) m_linked = 0;
            else m_idle++;
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic do_ll(input logic [31:0] a);
        cycle(0, 1, a, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic do_sc(input logic [31:0] a, input logic [31:0] d);
        cycle(0, 0, '0, 1, a, d, 0, '0, 0);
    endtask

    // Reset asserted mid-cycle: everything must clear without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #3;
        flush = 0; ll_i = 0; sc_i = 0; snoop_we_i = 0; bus_ack_i = 0;
        rst = 1'b0;
        #1;
        chk("rst_req",    bus_req_o,   0);
        chk("rst_addr",   bus_addr_o,  0);
        chk("rst_data",   bus_data_o,  0);
        chk("rst_stall",  stall_o,     0);
        chk("rst_done",   sc_done_o,   0);
        chk("rst_result", sc_result_o, 0);
        chk("rst_llbit",  LLbit_o,     0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic logic [31:0] raddr();
        return 32'h1000 + (32'($urandom_range(0, 3)) << 2) + 32'($urandom_range(0, 3));
    endfunction

    // Monitor: compare every recorded cycle against the DUT outputs.
    always @(negedge clk) begin
        obs_t o;
        #2;
        if (exp_q.size() > 0) begin
            o = exp_q.pop_front();
            chk("llbit",  LLbit_o,     o.llbit);
            chk("req",    bus_req_o,   o.req);
            chk("stall",  stall_o,     o.stall);
            chk("done",   sc_done_o,   o.done);
            if (o.done) chk("result", sc_result_o, o.res);
            if (o.req) begin
                chk("bus_addr", bus_addr_o, o.addr);
                chk("bus_data", bus_data_o, o.data);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("init_req",    bus_req_o,   0);
        chk("init_addr",   bus_addr_o,  0);
        chk("init_data",   bus_data_o,  0);
        chk("init_stall",  stall_o,     0);
        chk("init_done",   sc_done_o,   0);
        chk("init_result", sc_result_o, 0);
        chk("init_llbit",  LLbit_o,     0);
        @(negedge clk);
        rst = 1'b1;

        // LL/SC success with ack on the third request cycle.
        do_ll(32'h1000);
        do_sc(32'h1000, 32'hDEADBEEF);
        idle(2);
        cycle(0, 0, '0, 0, '0, '0, 0, '0, 1);
        idle(2);

        // Snoop to the same word kills the link.
        do_ll(32'h1000);
        cycle(0, 0, '0, 0, '0, '0, 1, 32'h1002, 0);
        do_sc(32'h1000, 32'h11111111);
        idle(2);

        // Snoop to a different word leaves the link intact.
        do_ll(32'h1000);
        cycle(0, 0, '0, 0, '0, '0, 1, 32'h1004, 0);
        do_sc(32'h1000, 32'h22222222);
        cycle(0, 0, '0, 0, '0, '0, 0, '0, 1);
        idle(2);

        // Matching snoop in the same cycle as SC loses to the SC.
        do_ll(32'h1008);
        cycle(0, 0, '0, 1, 32'h1008, 32'h33333333, 1, 32'h1008, 1);
        idle(2);

        // Flush while the store is in flight: handshake finishes silently.
        do_ll(32'h2000);
        do_sc(32'h2000, 32'h44444444);
        idle(1);
        cycle(1, 0, '0, 0, '0, '0, 0, '0, 0);
        idle(2);
        cycle(0, 0, '0, 0, '0, '0, 0, '0, 1);
        idle(2);

        // Idle link past the timeout, then SC.
        do_ll(32'h3000);
        idle(10);
        do_sc(32'h3000, 32'h55555555);
        idle(2);
        if (m_busy) begin
            cycle(0, 0, '0, 0, '0, '0, 0, '0, 1);
            idle(1);
        end

        // Reset during SC_BUSY, then SC without a link.
        do_ll(32'h4000);
        do_sc(32'h4000, 32'h66666666);
        idle(1);
        do_reset();
        do_sc(32'h4000, 32'h77777777);
        idle(2);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0, raddr(),
                  $urandom_range(0, 5) == 0, raddr(), $urandom(),
                  $urandom_range(0, 4) == 0, raddr(), $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 99) == 0) idle(TMO + 2);
            if ($urandom_range(0, 499) == 0) do_reset();
        end
        idle(3);
        @(negedge clk);
        @(negedge clk);
        #4;
        chk("drain", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_llsc_monitor

// File: doc/llsc_monitor.md
# llsc_monitor

Load-linked/store-conditional monitor for the MEM stage: it records the link address on LL, clears the link on matching snooped stores, flushes and timeouts, and resolves SC. A successful SC is issued to the data bus with a req/ack handshake, and the pipeline stalls until the bus acknowledges. A failed SC completes in one cycle without a bus access. `sc_result_o` is the value written to rt; `LLbit_o` exports the link state to CP0 and debug logic.

## Interface
Parameters:
- ADDR_W, 32: address width.
- LINK_LSB, 2: address bits below this index are ignored when comparing against the link address (word granularity).
- TIMEOUT, 1024: number of cycles a link may stay idle before it is dropped. Legal range 2..65535.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush  in  1  exception/eret flush.
- ll_i  in  1  LL commits this cycle.
- ll_addr_i  in  ADDR_W  LL address.
- sc_i  in  1  SC presented this cycle.
- sc_addr_i  in  ADDR_W  SC address.
- sc_data_i  in  32  SC store data.
- snoop_we_i  in  1  store from another master, or an ordinary store.
- snoop_addr_i  in  ADDR_W  address of the snooped store.
- bus_req_o  out  1  store request.
- bus_addr_o  out  ADDR_W  store address.
- bus_data_o  out  32  store data.
- bus_ack_i  in  1  store accepted.
- stall_o  out  1  pipeline hold.
- sc_done_o  out  1  one-cycle pulse: SC resolved.
- sc_result_o  out  1  1 = SC success, 0 = SC fail; valid while sc_done_o is high.
- LLbit_o  out  1  link valid.

## Operation
- States:
  - IDLE: no link.
  - LINKED: link_addr is valid.
  - SC_BUSY: SC store in flight.
- LLbit_o = (state != IDLE).
- Match rule: addr[ADDR_W-1:LINK_LSB] == link_addr[ADDR_W-1:LINK_LSB].
- Event priority within one cycle: rst > flush > sc_i > ll_i > snoop > timeout. If ll_i and sc_i are both high, ll_i is ignored.
- IDLE:
  - ll_i → LINKED; latch the address; clear the timeout counter.
  - sc_i → fail.
- LINKED:
  - sc_i with an address match → SC_BUSY; latch addr/data into the bus registers.
  - sc_i with an address mismatch → fail → IDLE.
  - ll_i → re-link to the new address; clear the counter.
  - snoop_we_i with an address match → IDLE.
  - Counter reaching TIMEOUT-1 → IDLE.
- SC_BUSY:
  - bus_req_o is held high, with stable addr/data, until bus_ack_i is sampled high.
  - On ack → IDLE; pulse sc_done_o with sc_result_o=1.
  - Snoop, ll_i and sc_i are ignored in this state.
- Fail: sc_done_o pulses on the next cycle with sc_result_o=0, link cleared, no bus request.
- Flush:
  - In IDLE or LINKED → IDLE; no sc_done_o.
  - In SC_BUSY the bus handshake still completes, but the sc_done_o pulse is suppressed and the state then goes to IDLE.

## Timing
- Reset values: state=IDLE, bus_req_o=0, bus_addr_o=0, bus_data_o=0, stall_o=0, sc_done_o=0, sc_result_o=0, LLbit_o=0, counter=0.
- LL in cycle t → LLbit_o=1 from cycle t+1.
- SC success:
  - Presented in cycle t → bus_req_o=1 from t+1.
  - bus_ack_i high in cycle t+k → bus_req_o=0, sc_done_o=1, LLbit_o=0 in cycle t+k+1.
  - Minimum latency is 2 cycles, with ack in t+1.
- stall_o is combinational: high in cycle t when sc_i hits in LINKED, and high throughout SC_BUSY. It drops in the cycle sc_done_o is high.
- SC fail: stall_o=0 throughout; sc_done_o high in cycle t+1.
- A snoop that matches in the same cycle as a matching SC loses: the SC proceeds and succeeds.
- The counter saturates; it does not wrap.
- Asserting rst mid-transaction drops bus_req_o immediately. The bus must tolerate an abandoned request.

## Configuration
- Macro LLSC_TIMEOUT_EN:
  - Defined: the counter and the timeout transition are built.
  - Undefined: no counter is built, the TIMEOUT parameter is unused, and a link persists until SC, re-LL, snoop, flush or rst.

## Structure
- Shared package/def.v holds:
  - state encodings LLSC_IDLE, LLSC_LINKED, LLSC_SC_BUSY;
  - the active-low reset level constant;
  - SC_SUCCESS / SC_FAIL.
- One sub-module, llsc_timer: a saturating counter with clear and expire outputs. It is instantiated only under LLSC_TIMEOUT_EN.

## Test plan
- LL 0x1000, then SC 0x1000 data 0xDEADBEEF, ack after 3 cycles → bus_req_o high 3 cycles with addr 0x1000 and data 0xDEADBEEF; sc_done_o=1, sc_result_o=1; LLbit_o=0.
- LL 0x1000, snoop store 0x1002, then SC 0x1000 → the snoop hits the same word, so sc_result_o=0, bus_req_o never asserted, stall_o stays 0.
- LL 0x1000, snoop store 0x1004, then SC 0x1000 → success.
- LL 0x2000, SC 0x2000 with ack withheld, flush in SC_BUSY → bus_req_o held until ack; no sc_done_o; LLbit_o=0.
- LL 0x3000, then TIMEOUT=8 cycles idle → LLbit_o falls after 8 cycles; a subsequent SC fails. With the macro undefined, LLbit_o stays 1.
- Assert rst during SC_BUSY → all outputs 0 immediately, state IDLE; after release, SC without a preceding LL fails.
